// File: rtl/if_prefetch_stage_if.sv
// Instruction/data memory port: master drives the request, slave answers with
// ready and read data in the same cycle the transfer completes.
interface mem_if #(
    parameter int ADDR_W = 32
) ();
    logic              m_valid;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata;
    logic [3:0]        m_wstrb;
    logic              s_ready;
    logic [31:0]       s_rdata;

    modport master (output m_valid, m_addr, m_wdata, m_wstrb, input s_ready, s_rdata);
    modport slave  (input m_valid, m_addr, m_wdata, m_wstrb, output s_ready, s_rdata);
endinterface

// File: rtl/if_prefetch_stage.sv
// Fetch stage with a FIFO_DEPTH-entry prefetch queue of {pc, instr} pairs.
// Optional performance counters are built when IFETCH_PERF_EN is defined.
module if_prefetch_stage #(
    parameter int                ADDR_W     = 32,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = {ADDR_W{1'b0}}
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_flush,
    input  logic [ADDR_W-1:0]                  i_redirect_pc,
    input  logic                               i_id_ready,
    mem_if.master                              imem,
    output logic                               o_if_valid,
    output logic [ADDR_W-1:0]                  o_if_pc,
    output logic [31:0]                        o_if_instr,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_fifo_count,
    output logic [31:0]                        o_perf_fetch_cnt,
    output logic [31:0]                        o_perf_wait_cnt,
    output logic [31:0]                        o_perf_flush_cnt
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [ADDR_W-1:0] pc_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [ADDR_W-1:0] pc_mem_r    [FIFO_DEPTH];
    logic [31:0]       instr_mem_r [FIFO_DEPTH];

    logic req_s;
    logic push_s;
    logic valid_s;
    logic pop_s;
    logic unused_redirect_lsb_s;

    // A full queue never requests: a same-cycle pop does not grant credit.
    assign req_s   = !rst && !i_flush && (count_r < CNT_W'(FIFO_DEPTH));
    assign push_s  = req_s && imem.s_ready;
    assign valid_s = !rst && !i_flush && (count_r != {CNT_W{1'b0}});
    assign pop_s   = valid_s && i_id_ready;

    assign unused_redirect_lsb_s = ^i_redirect_pc[1:0];

    assign imem.m_valid = req_s;
    assign imem.m_addr  = pc_r;
    assign imem.m_wdata = 32'd0;
    assign imem.m_wstrb = 4'b0000;

    assign o_if_valid   = valid_s;
    assign o_if_pc      = pc_mem_r[rd_ptr_r];
    assign o_if_instr   = instr_mem_r[rd_ptr_r];
    assign o_fifo_count = rst ? {CNT_W{1'b0}} : count_r;

    // Fetch PC, queue pointers and occupancy; reset beats flush beats traffic.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r     <= RESET_PC;
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (i_flush) begin
            pc_r     <= {i_redirect_pc[ADDR_W-1:2], 2'b00};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                pc_r     <= pc_r + ADDR_W'(4);
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                pc_r     <= pc_r;
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Queue storage; contents are qualified by count so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            pc_mem_r[wr_ptr_r]    <= pc_r;
            instr_mem_r[wr_ptr_r] <= imem.s_rdata;
        end else begin
            pc_mem_r[wr_ptr_r]    <= pc_mem_r[wr_ptr_r];
            instr_mem_r[wr_ptr_r] <= instr_mem_r[wr_ptr_r];
        end
    end

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_r;
    logic [31:0] perf_wait_r;
    logic [31:0] perf_flush_r;

    // Event counters, free-running and wrapping modulo 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_r <= 32'd0;
            perf_wait_r  <= 32'd0;
            perf_flush_r <= 32'd0;
        end else begin
            perf_fetch_r <= perf_fetch_r + (push_s ? 32'd1 : 32'd0);
            perf_wait_r  <= perf_wait_r + ((req_s && !imem.s_ready) ? 32'd1 : 32'd0);
            perf_flush_r <= perf_flush_r + (i_flush ? 32'd1 : 32'd0);
        end
    end

    assign o_perf_fetch_cnt = perf_fetch_r;
    assign o_perf_wait_cnt  = perf_wait_r;
    assign o_perf_flush_cnt = perf_flush_r;
`else
    assign o_perf_fetch_cnt = 32'd0;
    assign o_perf_wait_cnt  = 32'd0;
    assign o_perf_flush_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: directed then random steps checked against a
// queue-based reference model of the fetch stage.
module tb_if_prefetch_stage;
    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam int          DEPTH  = 4;

    logic        clk;
    logic        rst;
    logic        i_flush;
    logic [31:0] i_redirect_pc;
    logic        i_id_ready;
    logic        o_if_valid;
    logic [31:0] o_if_pc;
    logic [31:0] o_if_instr;
    logic [2:0]  o_fifo_count;
    logic [31:0] o_perf_fetch_cnt;
    logic [31:0] o_perf_wait_cnt;
    logic [31:0] o_perf_flush_cnt;

    mem_if #(.ADDR_W(32)) imem_bus ();

    if_prefetch_stage #(
        .ADDR_W    (32),
        .FIFO_DEPTH(DEPTH),
        .RESET_PC  (RST_PC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_flush         (i_flush),
        .i_redirect_pc   (i_redirect_pc),
        .i_id_ready      (i_id_ready),
        .imem            (imem_bus.master),
        .o_if_valid      (o_if_valid),
        .o_if_pc         (o_if_pc),
        .o_if_instr      (o_if_instr),
        .o_fifo_count    (o_fifo_count),
        .o_perf_fetch_cnt(o_perf_fetch_cnt),
        .o_perf_wait_cnt (o_perf_wait_cnt),
        .o_perf_flush_cnt(o_perf_flush_cnt)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_bus.s_rdata = mem_word(imem_bus.m_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          checks = 0;
    int          errors = 0;
    logic [63:0] q[$];
    logic [31:0] m_pc = RST_PC;
    logic [31:0] n_fetch = 32'd0;
    logic [31:0] n_wait = 32'd0;
    logic [31:0] n_flush = 32'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit fl, input bit sr, input bit idr, input logic [31:0] rpc);
        bit exp_mv;
        bit exp_ov;
        rst = r;
        i_flush = fl;
        imem_bus.s_ready = sr;
        i_id_ready = idr;
        i_redirect_pc = rpc;
        #2;
        exp_mv = !r && !fl && (q.size() < DEPTH);
        exp_ov = !r && !fl && (q.size() != 0);
        check("m_valid", 64'(imem_bus.m_valid), 64'(exp_mv));
        if (exp_mv) check("m_addr", 64'(imem_bus.m_addr), 64'(m_pc));
        check("m_wdata", 64'(imem_bus.m_wdata), 64'd0);
        check("m_wstrb", 64'(imem_bus.m_wstrb), 64'd0);
        check("if_valid", 64'(o_if_valid), 64'(exp_ov));
        if (exp_ov) begin
            check("if_pc", 64'(o_if_pc), 64'(q[0][63:32]));
            check("if_instr", 64'(o_if_instr), 64'(q[0][31:0]));
        end
        check("fifo_count", 64'(o_fifo_count), r ? 64'd0 : 64'(q.size()));
        if (!r) begin
`ifdef IFETCH_PERF_EN
            check("perf_fetch", 64'(o_perf_fetch_cnt), 64'(n_fetch));
            check("perf_wait", 64'(o_perf_wait_cnt), 64'(n_wait));
            check("perf_flush", 64'(o_perf_flush_cnt), 64'(n_flush));
`else
            check("perf_fetch", 64'(o_perf_fetch_cnt), 64'd0);
            check("perf_wait", 64'(o_perf_wait_cnt), 64'd0);
            check("perf_flush", 64'(o_perf_flush_cnt), 64'd0);
`endif
        end
        if (r) begin
            q.delete();
            m_pc = RST_PC;
            n_fetch = 32'd0;
            n_wait = 32'd0;
            n_flush = 32'd0;
        end else if (fl) begin
            q.delete();
            m_pc = rpc & 32'hFFFF_FFFC;
            n_flush = n_flush + 32'd1;
        end else begin
            if (exp_ov && idr) void'(q.pop_front());
            if (exp_mv && sr) begin
                q.push_back({m_pc, mem_word(m_pc)});
                m_pc = m_pc + 32'd4;
                n_fetch = n_fetch + 32'd1;
            end else if (exp_mv) begin
                n_wait = n_wait + 32'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        i_flush = 1'b0;
        i_redirect_pc = 32'd0;
        i_id_ready = 1'b0;
        imem_bus.s_ready = 1'b0;
        #1;
        // reset
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'd0);
        // streaming across the address wrap from RESET_PC
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 32'd0);
        // fill the queue with decode stalled, then a single pop
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        // redirect to 0x8 and stall memory for three cycles
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0008);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 32'd0);
        // three entries queued, then flush to misaligned 0x103
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0103);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 32'd0);
        // flush coincident with s_ready at pc 0x20
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0020);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 32'd0);
        // reset in the middle of a stall
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 32'd0);
        // redirect near top of the address space
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF5);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 32'd0);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 97) == 0, ($urandom % 13) == 0, ($urandom % 4) != 0,
                 ($urandom % 3) != 0, $urandom);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
